// File: rtl/move_recorder.sv
`default_nettype none
// ============================================================================
// move_recorder : packs the solver's push/undo/finish move stream into ord/cnt/comp
// Optional: REVERSE_CANCEL_EN folds a push opposite to the top move into an undo.
// Revision: 1.0
// ============================================================================
module move_recorder #(
  parameter int MAX_MOVES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mv_valid,
  input  logic [1:0]  mv_dir,
  output logic        mv_ready,
  input  logic        undo,
  input  logic        finish,
  output logic        comp,
  output logic [63:0] cnt,
  output logic [63:0] ord,
  output logic        overflow
);

  localparam int CNT_W = $clog2(MAX_MOVES + 1);
  localparam logic [CNT_W-1:0] C_MAX = CNT_W'(MAX_MOVES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REC  = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [63:0]      ord_q, ord_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             comp_q, comp_d;
  logic             overflow_q, overflow_d;

  logic [CNT_W-1:0] top_idx;
  logic [1:0]       top_dir;
  logic             has_top;
  logic             do_push;
  logic             do_pop;
  logic             wr_en;
  logic [CNT_W-1:0] wr_idx;
  logic [1:0]       wr_val;

  assign has_top = (cnt_q != '0);
  assign top_idx = has_top ? cnt_q - 1'b1 : '0;

  always_comb begin
    top_dir = 2'b00;
    for (int i = 0; i < MAX_MOVES; i++) begin
      if (i == int'(top_idx)) top_dir = ord_q[2*i +: 2];
    end
  end

  // Move codes pair as UP=0/DOWN=1 and LEFT=2/RIGHT=3, so the opposite flips bit 0.
  always_comb begin
    do_push = mv_valid;
    do_pop  = undo;
`ifdef REVERSE_CANCEL_EN
    if (mv_valid && !undo && has_top && (mv_dir == (top_dir ^ 2'b01))) begin
      do_push = 1'b0;
      do_pop  = 1'b1;
    end
`endif
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    comp_d     = comp_q;
    overflow_d = overflow_q;
    wr_en      = 1'b0;
    wr_idx     = '0;
    wr_val     = 2'b00;

    if (start) begin
      state_d    = ST_REC;
      cnt_d      = '0;
      comp_d     = 1'b0;
      overflow_d = 1'b0;
    end else if (state_q == ST_REC) begin
      if (do_push && do_pop && has_top) begin
        wr_en  = 1'b1;
        wr_idx = top_idx;
        wr_val = mv_dir;
      end else if (do_push && cnt_q < C_MAX) begin
        wr_en  = 1'b1;
        wr_idx = cnt_q;
        wr_val = mv_dir;
        cnt_d  = cnt_q + 1'b1;
      end else if (do_push) begin
        overflow_d = 1'b1;
        state_d    = ST_ERR;
      end else if (do_pop && has_top) begin
        wr_en  = 1'b1;
        wr_idx = top_idx;
        wr_val = 2'b00;
        cnt_d  = top_idx;
      end

      if (finish && state_d != ST_ERR) begin
        comp_d  = 1'b1;
        state_d = ST_DONE;
      end
    end
  end

  always_comb begin
    ord_d = ord_q;
    if (start) begin
      ord_d = '0;
    end else if (wr_en) begin
      for (int i = 0; i < MAX_MOVES; i++) begin
        if (i == int'(wr_idx)) ord_d[2*i +: 2] = wr_val;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ord_q      <= '0;
      cnt_q      <= '0;
      comp_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ord_q      <= ord_d;
      cnt_q      <= cnt_d;
      comp_q     <= comp_d;
      overflow_q <= overflow_d;
    end
  end

  assign mv_ready = (state_q == ST_REC);
  assign comp     = comp_q;
  assign overflow = overflow_q;
  assign ord      = ord_q;
  assign cnt      = {{(64-CNT_W){1'b0}}, cnt_q};

endmodule
`default_nettype wire

// File: tb/tb_move_recorder.sv
`default_nettype none
// ============================================================================
// tb_move_recorder : directed self-checking bench for move_recorder
// Revision: 1.0
// ============================================================================
module tb_move_recorder;

  localparam logic [1:0] UP = 2'd0, DOWN = 2'd1, LEFT = 2'd2, RIGHT = 2'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        mv_valid = 1'b0;
  logic [1:0]  mv_dir = 2'b00;
  logic        mv_ready;
  logic        undo = 1'b0;
  logic        finish = 1'b0;
  logic        comp;
  logic [63:0] cnt;
  logic [63:0] ord;
  logic        overflow;

  int errors = 0;
  int checks = 0;

  move_recorder #(.MAX_MOVES(32)) dut (
    .clk(clk), .rst(rst), .start(start), .mv_valid(mv_valid), .mv_dir(mv_dir),
    .mv_ready(mv_ready), .undo(undo), .finish(finish), .comp(comp),
    .cnt(cnt), .ord(ord), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Apply current inputs at the next edge, then release them and settle.
  task automatic tick();
    @(posedge clk);
    #1;
    rst = 1'b0; start = 1'b0; mv_valid = 1'b0; undo = 1'b0; finish = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; tick();
  endtask

  task automatic do_push(input logic [1:0] d);
    mv_valid = 1'b1; mv_dir = d; tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; tick();
    checks++; if (cnt !== 64'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", cnt); end
    checks++; if (ord !== 64'd0) begin errors++; $display("FAIL reset_ord got=%h exp=0", ord); end
    checks++; if ({mv_ready, comp, overflow} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got=%b exp=000", {mv_ready, comp, overflow}); end
    do_push(UP);
    checks++; if (cnt !== 64'd0) begin errors++; $display("FAIL idle_push_cnt got=%0d exp=0", cnt); end
  endtask

  task automatic test_basic();
    do_start();
    checks++; if (mv_ready !== 1'b1) begin errors++; $display("FAIL start_ready got=%b exp=1", mv_ready); end
    do_push(UP); do_push(LEFT);
    mv_valid = 1'b1; mv_dir = LEFT; finish = 1'b1; tick();
    checks++; if (cnt !== 64'd3) begin errors++; $display("FAIL basic_cnt got=%0d exp=3", cnt); end
    checks++; if (ord !== 64'h28) begin errors++; $display("FAIL basic_ord got=%h exp=28", ord); end
    checks++; if ({comp, mv_ready} !== 2'b10) begin
      errors++; $display("FAIL basic_comp_ready got=%b exp=10", {comp, mv_ready}); end
  endtask

  task automatic test_undo();
    do_start();
    do_push(RIGHT); do_push(LEFT);
    checks++; if (ord !== 64'hB) begin errors++; $display("FAIL undo_pre_ord got=%h exp=b", ord); end
    undo = 1'b1; tick();
    checks++; if (cnt !== 64'd1 || ord !== 64'h3) begin
      errors++; $display("FAIL undo1 got cnt=%0d ord=%h exp cnt=1 ord=3", cnt, ord); end
    undo = 1'b1; tick();
    checks++; if (cnt !== 64'd0 || ord !== 64'h0) begin
      errors++; $display("FAIL undo2 got cnt=%0d ord=%h exp cnt=0 ord=0", cnt, ord); end
    undo = 1'b1; tick();
    checks++; if (cnt !== 64'd0 || ord !== 64'h0 || overflow !== 1'b0 || mv_ready !== 1'b1) begin
      errors++; $display("FAIL undo3 got cnt=%0d ord=%h ovf=%b rdy=%b exp 0 0 0 1", cnt, ord, overflow, mv_ready); end
  endtask

  task automatic test_overflow();
    logic [63:0] exp_ord;
    logic [1:0]  d;
    exp_ord = '0;
    do_start();
    for (int i = 0; i < 32; i++) begin
      d = (i % 2 == 1) ? LEFT : UP;
      exp_ord[2*i +: 2] = d;
      do_push(d);
    end
    checks++; if (cnt !== 64'd32 || ord !== exp_ord) begin
      errors++; $display("FAIL full got cnt=%0d ord=%h exp cnt=32 ord=%h", cnt, ord, exp_ord); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_no_ovf got=%b exp=0", overflow); end
    mv_valid = 1'b1; mv_dir = UP; finish = 1'b1; tick();
    checks++; if (cnt !== 64'd32 || ord !== exp_ord) begin
      errors++; $display("FAIL ovf_hold got cnt=%0d ord=%h exp cnt=32 ord=%h", cnt, ord, exp_ord); end
    checks++; if ({overflow, mv_ready, comp} !== 3'b100) begin
      errors++; $display("FAIL ovf_flags got=%b exp=100", {overflow, mv_ready, comp}); end
    undo = 1'b1; tick();
    checks++; if (cnt !== 64'd32) begin errors++; $display("FAIL err_undo got=%0d exp=32", cnt); end
    start = 1'b1; mv_valid = 1'b1; mv_dir = RIGHT; tick();
    checks++; if (cnt !== 64'd0 || ord !== 64'd0 || overflow !== 1'b0 || mv_ready !== 1'b1) begin
      errors++; $display("FAIL restart got cnt=%0d ord=%h ovf=%b rdy=%b exp 0 0 0 1", cnt, ord, overflow, mv_ready); end
  endtask

  task automatic test_same_cycle();
    do_start();
    do_push(UP); do_push(LEFT);
    mv_valid = 1'b1; mv_dir = RIGHT; undo = 1'b1; tick();
    checks++; if (cnt !== 64'd2 || ord !== 64'hC) begin
      errors++; $display("FAIL push_undo got cnt=%0d ord=%h exp cnt=2 ord=c", cnt, ord); end
    mv_valid = 1'b1; mv_dir = DOWN; finish = 1'b1; tick();
    checks++; if (cnt !== 64'd3 || ord !== 64'h1C || comp !== 1'b1) begin
      errors++; $display("FAIL push_finish got cnt=%0d ord=%h comp=%b exp 3 1c 1", cnt, ord, comp); end
    do_push(UP);
    undo = 1'b1; tick();
    checks++; if (cnt !== 64'd3 || ord !== 64'h1C || comp !== 1'b1 || mv_ready !== 1'b0) begin
      errors++; $display("FAIL done_hold got cnt=%0d ord=%h comp=%b rdy=%b exp 3 1c 1 0", cnt, ord, comp, mv_ready); end
    do_start();
    mv_valid = 1'b1; mv_dir = LEFT; undo = 1'b1; tick();
    checks++; if (cnt !== 64'd1 || ord !== 64'h2) begin
      errors++; $display("FAIL push_undo_empty got cnt=%0d ord=%h exp 1 2", cnt, ord); end
  endtask

  task automatic test_reverse();
    do_start();
    do_push(UP); do_push(DOWN);
`ifdef REVERSE_CANCEL_EN
    checks++; if (cnt !== 64'd0 || ord !== 64'd0) begin
      errors++; $display("FAIL reverse got cnt=%0d ord=%h exp 0 0", cnt, ord); end
`else
    checks++; if (cnt !== 64'd2 || ord !== 64'h4) begin
      errors++; $display("FAIL reverse got cnt=%0d ord=%h exp 2 4", cnt, ord); end
`endif
  endtask

  task automatic test_reset_mid();
    do_start();
    do_push(UP); do_push(LEFT); do_push(UP); do_push(LEFT); do_push(RIGHT);
    checks++; if (cnt !== 64'd5 || ord !== 64'h388) begin
      errors++; $display("FAIL mid_pre got cnt=%0d ord=%h exp 5 388", cnt, ord); end
    rst = 1'b1; mv_valid = 1'b1; mv_dir = UP; tick();
    checks++; if (cnt !== 64'd0 || ord !== 64'd0 || {mv_ready, comp, overflow} !== 3'b000) begin
      errors++; $display("FAIL mid_reset got cnt=%0d ord=%h flags=%b exp 0 0 000", cnt, ord, {mv_ready, comp, overflow}); end
  endtask

  initial begin
    #2;
    test_reset();
    test_basic();
    test_undo();
    test_overflow();
    test_same_cycle();
    test_reverse();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
